// File: rtl/ws_array_ctrl.sv
// Job sequencer for a 4x4 weight-stationary systolic array: loads weights, clears accumulators,
// streams column-skewed input vectors, drains the pipeline and holds the captured neuron sums.
module ws_array_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int ACC_WIDTH    = 64,
  parameter int NEURON_NUM   = 4,
  parameter int WEIGHT_WIDTH = DATA_WIDTH*16,
  parameter int CNT_W        = 16,
  parameter int PIPE_LAT     = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CNT_W-1:0]               num_vec_i,
  input  logic [WEIGHT_WIDTH-1:0]        weight_i,
  output logic                           busy,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [4*DATA_WIDTH-1:0]        in_data,
  output logic                           arr_load_en,
  output logic                           arr_acc_en,
  output logic                           arr_rstn_acc,
  output logic [WEIGHT_WIDTH-1:0]        arr_weight_o,
  output logic [4*DATA_WIDTH-1:0]        arr_data_o,
  input  logic [ACC_WIDTH*NEURON_NUM-1:0] arr_acc_i,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [ACC_WIDTH*NEURON_NUM-1:0] res_data
);

  localparam int DRAIN_CYC = 3 + PIPE_LAT;
  localparam int DRN_W     = $clog2(DRAIN_CYC);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, STREAM, DRAIN, DONE} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [CNT_W-1:0]                num_vec_q, num_vec_d;
  logic [DRN_W-1:0]                drain_q, drain_d;
  logic                            busy_q, busy_d;
  logic                            in_ready_q, in_ready_d;
  logic                            load_en_q, load_en_d;
  logic                            acc_en_q, acc_en_d;
  logic                            rstn_acc_q, rstn_acc_d;
  logic [WEIGHT_WIDTH-1:0]         weight_q, weight_d;
  logic                            res_valid_q, res_valid_d;
  logic [ACC_WIDTH*NEURON_NUM-1:0] res_data_q, res_data_d;
  logic [DATA_WIDTH-1:0]           sk1_q, sk1_d;
  logic [1:0][DATA_WIDTH-1:0]      sk2_q, sk2_d;
  logic [2:0][DATA_WIDTH-1:0]      sk3_q, sk3_d;
  logic [4*DATA_WIDTH-1:0]         data_q, data_d;
  logic                            accept;
  logic [4*DATA_WIDTH-1:0]         inj;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    num_vec_d   = num_vec_q;
    drain_d     = drain_q;
    busy_d      = busy_q;
    in_ready_d  = 1'b0;
    load_en_d   = 1'b0;
    acc_en_d    = 1'b0;
    rstn_acc_d  = 1'b1;
    weight_d    = weight_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    accept      = (state_q == STREAM) && in_ready_q && in_valid;

    // Outputs are computed for the state being entered so each is registered yet aligned with it.
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          num_vec_d = num_vec_i;
          cnt_d     = num_vec_i;
          weight_d  = weight_i;
          busy_d    = 1'b1;
          load_en_d = 1'b1;
        end
      end
      LOAD: begin
        state_d    = CLEAR;
        rstn_acc_d = 1'b0;
      end
      CLEAR: begin
        acc_en_d = 1'b1;
        drain_d  = '0;
        if (cnt_q == '0) begin
          state_d = DRAIN;
        end else begin
          state_d    = STREAM;
          in_ready_d = 1'b1;
        end
      end
      STREAM: begin
        acc_en_d   = 1'b1;
        in_ready_d = 1'b1;
        if (accept) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d    = DRAIN;
            in_ready_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d     = DONE;
          cnt_d       = num_vec_q;
          res_data_d  = arr_acc_i;
          res_valid_d = 1'b1;
        end else begin
          drain_d  = drain_q + 1'b1;
          acc_en_d = 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Idle cycles inject zero lanes so bubbles add nothing and the diagonal skew stays aligned.
  always_comb begin
    inj      = accept ? in_data : '0;
    sk1_d    = inj[2*DATA_WIDTH-1 -: DATA_WIDTH];
    sk2_d[0] = inj[3*DATA_WIDTH-1 -: DATA_WIDTH];
    sk2_d[1] = sk2_q[0];
    sk3_d[0] = inj[4*DATA_WIDTH-1 -: DATA_WIDTH];
    sk3_d[1] = sk3_q[0];
    sk3_d[2] = sk3_q[1];
    data_d   = {sk3_q[2], sk2_q[1], sk1_q, inj[DATA_WIDTH-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      num_vec_q   <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      load_en_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      rstn_acc_q  <= 1'b0;
      weight_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      sk1_q       <= '0;
      sk2_q       <= '0;
      sk3_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_vec_q   <= num_vec_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      load_en_q   <= load_en_d;
      acc_en_q    <= acc_en_d;
      rstn_acc_q  <= rstn_acc_d;
      weight_q    <= weight_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      sk1_q       <= sk1_d;
      sk2_q       <= sk2_d;
      sk3_q       <= sk3_d;
      data_q      <= data_d;
    end
  end

  assign busy         = busy_q;
  assign in_ready     = in_ready_q;
  assign arr_load_en  = load_en_q;
  assign arr_acc_en   = acc_en_q;
  assign arr_rstn_acc = rstn_acc_q;
  assign arr_weight_o = weight_q;
  assign arr_data_o   = data_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;

endmodule

// File: tb/tb_ws_array_ctrl.sv
// Testbench for ws_array_ctrl: a behavioural 4x4 array model answers the controller, and job
// results are checked against plain dot-product arithmetic over the stimulus vectors.
module tb_ws_array_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic [15:0]  num_vec_i;
  logic [255:0] weight_i;
  logic         busy;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         arr_load_en;
  logic         arr_acc_en;
  logic         arr_rstn_acc;
  logic [255:0] arr_weight_o;
  logic [63:0]  arr_data_o;
  logic [255:0] arr_acc_i;
  logic         res_valid;
  logic         res_ready;
  logic [255:0] res_data;

  int errors = 0;
  int checks = 0;

  logic [63:0] vecs [16];
  logic [63:0] inj_hist [512];
  logic [63:0] out_hist [512];
  int          hist_len;

  ws_array_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_vec_i(num_vec_i), .weight_i(weight_i),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .arr_load_en(arr_load_en), .arr_acc_en(arr_acc_en), .arr_rstn_acc(arr_rstn_acc),
    .arr_weight_o(arr_weight_o), .arr_data_o(arr_data_o), .arr_acc_i(arr_acc_i),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] mac(input logic [255:0] acc, input logic [255:0] w,
                                       input logic [63:0] d);
    logic [255:0] r_v;
    longint s;
    r_v = acc;
    for (int r = 0; r < 4; r++) begin
      s = longint'(acc[64*r +: 64]);
      for (int c = 0; c < 4; c++)
        s += longint'(shortint'(w[16*(4*r+c) +: 16])) * longint'(shortint'(d[16*c +: 16]));
      r_v[64*r +: 64] = s;
    end
    return r_v;
  endfunction

  // Array model: weights latched on load_en, MAC per cycle, then a 4-register result pipe.
  logic [255:0] m_w;
  logic [255:0] m_acc;
  logic [255:0] m_pipe [4];
  always @(posedge clk) begin
    if (arr_load_en) m_w <= arr_weight_o;
    if (!arr_rstn_acc) begin
      m_acc <= '0;
      for (int i = 0; i < 4; i++) m_pipe[i] <= '0;
    end else begin
      if (arr_acc_en) m_acc <= mac(m_acc, m_w, arr_data_o);
      m_pipe[0] <= m_acc;
      for (int i = 1; i < 4; i++) m_pipe[i] <= m_pipe[i-1];
    end
  end
  assign arr_acc_i = m_pipe[3];

  function automatic logic [255:0] ref_result(input logic [255:0] w, input int nv);
    logic [255:0] r_v;
    r_v = '0;
    for (int v = 0; v < nv; v++) r_v = mac(r_v, w, vecs[v]);
    return r_v;
  endfunction

  function automatic logic [63:0] pack4(input shortint a, input shortint b, input shortint c,
                                        input shortint d);
    return {d, c, b, a};
  endfunction

  function automatic logic [255:0] ident_w();
    logic [255:0] w;
    w = '0;
    for (int r = 0; r < 4; r++) w[16*(5*r) +: 16] = 16'd1;
    return w;
  endfunction

  function automatic logic [255:0] rand_w();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom();
    return w;
  endfunction

  // Issues a job and runs it until res_valid (bounded); records injected and array-side lanes per cycle.
  task automatic run_to_result(input logic [255:0] w, input int nv, input int mode,
                               output logic [255:0] res, output int lat, output int loads,
                               output int busy_low);
    int          idx;
    int          cyc;
    logic [63:0] pend;
    bit          tog;
    bit          v;
    idx = 0; cyc = 0; pend = '0; tog = 1'b1; loads = 0; busy_low = 0; lat = -1; res = '0;
    start = 1'b1; num_vec_i = 16'(nv); weight_i = w;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    while (cyc < 400) begin
      inj_hist[cyc] = pend;
      out_hist[cyc] = arr_data_o;
      hist_len = cyc + 1;
      if (arr_load_en) loads++;
      if (!busy) busy_low++;
      if (res_valid) begin
        lat = cyc;
        res = res_data;
        break;
      end
      pend = '0;
      in_valid = 1'b0;
      in_data = {$urandom(), $urandom()};
      if (in_ready && idx < nv) begin
        v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 1) == 1);
        tog = ~tog;
        if (v) begin
          in_valid = 1'b1;
          in_data = vecs[idx];
          pend = vecs[idx];
          idx++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, in_ready, arr_load_en, arr_acc_en, res_valid, arr_rstn_acc} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000",
               {busy, in_ready, arr_load_en, arr_acc_en, res_valid, arr_rstn_acc});
    end
    checks++;
    if (arr_data_o !== 64'h0 || arr_weight_o !== 256'h0 || res_data !== 256'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got data=%h w=%h res=%h expected all zero",
               arr_data_o, arr_weight_o, res_data);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (arr_rstn_acc !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: got rstn_acc=%b busy=%b expected 1 0", arr_rstn_acc, busy);
    end
  endtask

  task automatic test_identity_one();
    logic [255:0] res;
    int lat, loads, bl;
    vecs[0] = pack4(1, 2, 3, 4);
    run_to_result(ident_w(), 1, 0, res, lat, loads, bl);
    checks++;
    if (res !== {64'd4, 64'd3, 64'd2, 64'd1}) begin
      errors++;
      $display("[TB] FAIL ident1_result: got %h expected {4,3,2,1}", res);
    end
    checks++;
    if (loads !== 1) begin
      errors++;
      $display("[TB] FAIL ident1_load_cycles: got %0d expected 1", loads);
    end
    checks++;
    if (lat !== 13) begin
      errors++;
      $display("[TB] FAIL ident1_latency: got %0d expected 13", lat);
    end
    accept_result();
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ident1_handshake: got busy=%b valid=%b expected 0 0", busy, res_valid);
    end
  endtask

  task automatic test_identity_two();
    logic [255:0] res;
    int lat, loads, bl;
    vecs[0] = pack4(1, 2, 3, 4);
    vecs[1] = pack4(10, 20, 30, 40);
    run_to_result(ident_w(), 2, 0, res, lat, loads, bl);
    checks++;
    if (res !== {64'd44, 64'd33, 64'd22, 64'd11}) begin
      errors++;
      $display("[TB] FAIL ident2_result: got %h expected {44,33,22,11}", res);
    end
    checks++;
    if (bl !== 0 || lat < 0) begin
      errors++;
      $display("[TB] FAIL ident2_busy: got %0d busy-low cycles (lat %0d) expected 0", bl, lat);
    end
    accept_result();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ident2_busy_drop: got %b expected 0", busy);
    end
  endtask

  task automatic test_toggle_skew();
    logic [255:0] res, w;
    logic [255:0] expv;
    logic [15:0]  e;
    int lat, loads, bl, bad;
    for (int k = 0; k < 16; k++) w[16*k +: 16] = 16'd2;
    for (int v = 0; v < 3; v++) vecs[v] = pack4(-1, -2, -3, -4);
    expv = {4{64'hFFFF_FFFF_FFFF_FFC4}};
    run_to_result(w, 3, 1, res, lat, loads, bl);
    checks++;
    if (res !== expv) begin
      errors++;
      $display("[TB] FAIL toggle_result: got %h expected %h", res, expv);
    end
    bad = 0;
    for (int t = 1; t < hist_len; t++)
      for (int c = 0; c < 4; c++) begin
        e = (t - c >= 1) ? inj_hist[t-c][16*c +: 16] : 16'h0;
        if (out_hist[t][16*c +: 16] !== e && bad == 0) begin
          bad = 1;
          $display("[TB] FAIL toggle_skew: cycle %0d lane %0d got %h expected %h",
                   t, c, out_hist[t][16*c +: 16], e);
        end
      end
    checks++;
    if (bad != 0) errors++;
    accept_result();
  endtask

  task automatic test_zero_vec();
    logic [255:0] res;
    int lat, loads, bl;
    run_to_result(rand_w(), 0, 0, res, lat, loads, bl);
    checks++;
    if (res !== 256'h0) begin
      errors++;
      $display("[TB] FAIL zero_result: got %h expected 0", res);
    end
    checks++;
    if (lat !== 12 || loads !== 1) begin
      errors++;
      $display("[TB] FAIL zero_timing: got lat=%0d loads=%0d expected 12 1", lat, loads);
    end
    accept_result();
  endtask

  task automatic test_hold();
    logic [255:0] res;
    int lat, loads, bl;
    vecs[0] = pack4(1, 2, 3, 4);
    run_to_result(ident_w(), 1, 0, res, lat, loads, bl);
    for (int i = 0; i < 10; i++) begin
      res_ready = 1'b0;
      start = ($urandom_range(0, 1) == 1);
      num_vec_i = 16'($urandom_range(0, 5));
      weight_i = rand_w();
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || busy !== 1'b1 || arr_load_en !== 1'b0 ||
          res_data !== {64'd4, 64'd3, 64'd2, 64'd1} || arr_weight_o !== ident_w()) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: got valid=%b busy=%b load=%b res=%h expected 1 1 0 {4,3,2,1}",
                 i, res_valid, busy, arr_load_en, res_data);
      end
    end
    start = 1'b1;
    accept_result();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_release: got busy=%b valid=%b expected 0 0", busy, res_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (arr_load_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_same_cycle_start: got load=%b busy=%b expected 0 0", arr_load_en, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] res;
    int lat, loads, bl, wait_cyc;
    start = 1'b1; num_vec_i = 16'd5; weight_i = ident_w();
    @(posedge clk); #1;
    start = 1'b0;
    wait_cyc = 0;
    while (!in_ready && wait_cyc < 10) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    in_valid = 1'b1; in_data = pack4(7, 7, 7, 7);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, arr_load_en, arr_acc_en, res_valid, arr_rstn_acc} !== 6'b0 ||
        arr_data_o !== 64'h0 || arr_weight_o !== 256'h0 || res_data !== 256'h0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got ctrl=%b data=%h expected all zero",
               {busy, in_ready, arr_load_en, arr_acc_en, res_valid, arr_rstn_acc}, arr_data_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    vecs[0] = pack4(1, 2, 3, 4);
    run_to_result(ident_w(), 1, 0, res, lat, loads, bl);
    checks++;
    if (res !== {64'd4, 64'd3, 64'd2, 64'd1}) begin
      errors++;
      $display("[TB] FAIL midreset_rerun: got %h expected {4,3,2,1}", res);
    end
    accept_result();
  endtask

  task automatic test_random();
    logic [255:0] res, w, expv;
    logic [15:0]  e;
    int lat, loads, bl, nv, bad;
    for (int j = 0; j < 6; j++) begin
      w = rand_w();
      nv = $urandom_range(1, 5);
      for (int v = 0; v < nv; v++) vecs[v] = {$urandom(), $urandom()};
      expv = ref_result(w, nv);
      run_to_result(w, nv, 2, res, lat, loads, bl);
      checks++;
      if (res !== expv || lat < 0) begin
        errors++;
        $display("[TB] FAIL random_job%0d: got %h (lat %0d) expected %h", j, res, lat, expv);
      end
      bad = 0;
      for (int t = 1; t < hist_len; t++)
        for (int c = 0; c < 4; c++) begin
          e = (t - c >= 1) ? inj_hist[t-c][16*c +: 16] : 16'h0;
          if (out_hist[t][16*c +: 16] !== e && bad == 0) begin
            bad = 1;
            $display("[TB] FAIL random_skew%0d: cycle %0d lane %0d got %h expected %h",
                     j, t, c, out_hist[t][16*c +: 16], e);
          end
        end
      checks++;
      if (bad != 0) errors++;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      accept_result();
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL random_done%0d: got busy=%b valid=%b expected 0 0", j, busy, res_valid);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_vec_i = '0; weight_i = '0;
    in_valid = 1'b0; in_data = '0; res_ready = 1'b0; hist_len = 0;
    test_reset();
    test_identity_one();
    test_identity_two();
    test_toggle_skew();
    test_zero_vec();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
